// File: rtl/surf_infra_pkg.sv
`default_nettype none
// Shared defaults and helpers for the SURF LAB TREF/HOLD infrastructure.
package surf_infra_pkg;

  localparam int DEF_DIV_WIDTH    = 8;
  localparam int DEF_DEFAULT_DIV  = 0;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_HOLD_TIMEOUT = 1024;

  // Width needed for a counter that must be able to hold the value `timeout`.
  function automatic int stuck_cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/surf_hold_sync.sv
`default_nettype none
// Single-channel HOLD resynchroniser with rising-edge pulse and sticky stuck flag.
module surf_hold_sync
  import surf_infra_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int HOLD_TIMEOUT = DEF_HOLD_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic hold_i,
  input  logic stuck_clr_i,
  output logic hold_o,
  output logic hold_rise_o,
  output logic hold_stuck_o
);

  localparam int              CW      = stuck_cnt_width(HOLD_TIMEOUT);
  localparam logic [CW-1:0]   TIMEOUT = CW'(HOLD_TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hold_prev;
  logic [CW-1:0]          stuck_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      hold_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], hold_i};
      hold_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign hold_o      = sync_q[SYNC_STAGES-1];
  assign hold_rise_o = hold_o & ~hold_prev;

  // Clear has priority so a clear coinciding with the timeout leaves the flag low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stuck_cnt    <= '0;
      hold_stuck_o <= 1'b0;
    end else if (stuck_clr_i) begin
      stuck_cnt    <= '0;
      hold_stuck_o <= 1'b0;
    end else if (!hold_o) begin
      stuck_cnt    <= '0;
    end else if (stuck_cnt != TIMEOUT) begin
      stuck_cnt <= stuck_cnt + CW'(1);
      if (stuck_cnt == TIMEOUT - CW'(1)) begin
        hold_stuck_o <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/surf_lab_tref_hold_ctrl.sv
`default_nettype none
// Phase-aligned TREF strobe generator plus per-LAB HOLD resynchronisation.
module surf_lab_tref_hold_ctrl
  import surf_infra_pkg::*;
#(
  parameter int NUM_LAB      = 4,
  parameter int DIV_WIDTH    = DEF_DIV_WIDTH,
  parameter int DEFAULT_DIV  = DEF_DEFAULT_DIV,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int HOLD_TIMEOUT = DEF_HOLD_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_load_i,
  input  logic                 sync_i,
  input  logic [NUM_LAB-1:0]   lab_en_i,
  output logic [NUM_LAB-1:0]   tref_o,
  input  logic [NUM_LAB-1:0]   hold_i,
  output logic [NUM_LAB-1:0]   hold_o,
  output logic [NUM_LAB-1:0]   hold_rise_o,
  output logic [NUM_LAB-1:0]   hold_stuck_o,
  input  logic [NUM_LAB-1:0]   stuck_clr_i
);

  localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(DEFAULT_DIV);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_act;
  logic [DIV_WIDTH-1:0] div_pend;
  logic                 phase;
  logic [NUM_LAB-1:0]   en_q;
  logic                 wrap;
  logic                 phase_nxt;
  logic [NUM_LAB-1:0]   en_nxt;

  assign wrap = (cnt == div_act);

  // Enables are only sampled when a high phase begins, so a running pulse never gets cut short.
  always_comb begin
    phase_nxt = phase;
    en_nxt    = en_q;
    if (sync_i) begin
      phase_nxt = 1'b1;
      en_nxt    = lab_en_i;
    end else if (wrap) begin
      phase_nxt = ~phase;
      if (!phase) begin
        en_nxt = lab_en_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      phase    <= 1'b0;
      div_act  <= RST_DIV;
      div_pend <= RST_DIV;
      en_q     <= '0;
      tref_o   <= '0;
    end else begin
      phase  <= phase_nxt;
      en_q   <= en_nxt;
      tref_o <= {NUM_LAB{phase_nxt}} & en_nxt;
      if (sync_i) begin
        cnt     <= '0;
        div_act <= div_load_i ? div_i : div_pend;
      end else if (wrap) begin
        cnt     <= '0;
        div_act <= div_pend;
      end else begin
        cnt <= cnt + DIV_WIDTH'(1);
      end
      if (div_load_i) begin
        div_pend <= div_i;
      end
    end
  end

  for (genvar i = 0; i < NUM_LAB; i++) begin : g_lab
    surf_hold_sync #(
      .SYNC_STAGES  (SYNC_STAGES),
      .HOLD_TIMEOUT (HOLD_TIMEOUT)
    ) u_hold_sync (
      .clk          (clk),
      .rst          (rst),
      .hold_i       (hold_i[i]),
      .stuck_clr_i  (stuck_clr_i[i]),
      .hold_o       (hold_o[i]),
      .hold_rise_o  (hold_rise_o[i]),
      .hold_stuck_o (hold_stuck_o[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_surf_lab_tref_hold_ctrl.sv
`default_nettype none
// Self-checking bench: directed scenarios plus random traffic against a half-period segment model.
module tb_surf_lab_tref_hold_ctrl;

  localparam int NL = 4;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] div_i;
  logic          div_load_i;
  logic          sync_i;
  logic [NL-1:0] lab_en_i;
  logic [NL-1:0] hold_i;
  logic [NL-1:0] stuck_clr_i;
  logic [NL-1:0] tref_o;
  logic [NL-1:0] hold_o;
  logic [NL-1:0] hold_rise_o;
  logic [NL-1:0] hold_stuck_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  surf_lab_tref_hold_ctrl #(
    .NUM_LAB      (NL),
    .DIV_WIDTH    (DW),
    .DEFAULT_DIV  (0),
    .SYNC_STAGES  (SS),
    .HOLD_TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .div_i        (div_i),
    .div_load_i   (div_load_i),
    .sync_i       (sync_i),
    .lab_en_i     (lab_en_i),
    .tref_o       (tref_o),
    .hold_i       (hold_i),
    .hold_o       (hold_o),
    .hold_rise_o  (hold_rise_o),
    .hold_stuck_o (hold_stuck_o),
    .stuck_clr_i  (stuck_clr_i)
  );

  // Reference: TREF is a sequence of half-period segments of length (div+1),
  // alternating low/high; the LAB mask is adopted when a high segment starts.
  int            m_pos;
  int            m_act;
  int            m_pend;
  int            m_lvl;
  logic [NL-1:0] m_mask;
  logic [NL-1:0] m_hist[$];
  logic [NL-1:0] m_hold;
  logic [NL-1:0] m_hold_prev;
  logic [NL-1:0] m_stuck;
  int            m_run[NL];

  function automatic void model_reset();
    m_pos = 1; m_act = 0; m_pend = 0; m_lvl = 0; m_mask = '0;
    m_hist = {};
    for (int k = 0; k < SS; k++) m_hist.push_back('0);
    m_hold = '0; m_hold_prev = '0; m_stuck = '0;
    for (int k = 0; k < NL; k++) m_run[k] = 0;
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < NL; k++) begin
      if (stuck_clr_i[k]) begin
        m_run[k] = 0; m_stuck[k] = 1'b0;
      end else if (!m_hold[k]) begin
        m_run[k] = 0;
      end else if (m_run[k] < TO) begin
        m_run[k]++;
        if (m_run[k] == TO) m_stuck[k] = 1'b1;
      end
    end
    m_hist.push_front(hold_i);
    void'(m_hist.pop_back());
    m_hold_prev = m_hold;
    m_hold      = m_hist[SS-1];

    if (sync_i) begin
      m_act = div_load_i ? int'(div_i) : m_pend;
      m_lvl = 1; m_mask = lab_en_i; m_pos = 1;
    end else if (m_pos == m_act + 1) begin
      m_act = m_pend;
      m_lvl = 1 - m_lvl;
      if (m_lvl == 1) m_mask = lab_en_i;
      m_pos = 1;
    end else begin
      m_pos++;
    end
    if (div_load_i) m_pend = int'(div_i);
  endfunction

  task automatic check(input string tag, input logic [NL-1:0] obs, input logic [NL-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [NL-1:0] exp_tref;
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    exp_tref = (m_lvl != 0) ? m_mask : '0;
    check("tref", tref_o, exp_tref);
    check("hold", hold_o, m_hold);
    check("hold_rise", hold_rise_o, m_hold & ~m_hold_prev);
    check("hold_stuck", hold_stuck_o, m_stuck);
  endtask

  initial begin
    rst = 1'b1; div_i = '0; div_load_i = 1'b0; sync_i = 1'b0;
    lab_en_i = '0; hold_i = '0; stuck_clr_i = '0;
    model_reset();
    step();
    check("rst_tref", tref_o, 4'b0000);
    check("rst_stuck", hold_stuck_o, 4'b0000);
    step();
    rst = 1'b0;
    repeat (3) step();

    // All LABs on at DIV=0: clk/2 strobes, high right after sync.
    lab_en_i = 4'b1111; sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    check("sync_first_high", tref_o, 4'b1111);
    step();
    check("div0_low", tref_o, 4'b0000);
    step();
    check("div0_high", tref_o, 4'b1111);
    repeat (4) step();

    // Divider change mid-period.
    div_i = 8'd3; div_load_i = 1'b1;
    step();
    div_load_i = 1'b0;
    repeat (20) step();

    // Drop LAB2 inside a high phase, then re-enable.
    for (int k = 0; k < 16 && !(m_lvl == 1 && m_pos == 2); k++) step();
    lab_en_i = 4'b1011;
    repeat (24) step();
    lab_en_i = 4'b1111;
    repeat (24) step();

    // HOLD pulse on LAB1.
    hold_i = 4'b0010;
    step();
    step();
    check("hold1_rise", hold_rise_o, 4'b0010);
    step();
    check("hold1_rise_once", hold_rise_o, 4'b0000);
    hold_i = 4'b0000;
    repeat (4) step();

    // Stuck HOLD on LAB0.
    hold_i = 4'b0001;
    repeat (18) step();
    check("stuck_set", hold_stuck_o, 4'b0001);
    stuck_clr_i = 4'b0001;
    step();
    stuck_clr_i = 4'b0000;
    check("stuck_cleared", hold_stuck_o, 4'b0000);
    repeat (15) step();
    step();
    check("stuck_reset_again", hold_stuck_o, 4'b0001);
    stuck_clr_i = 4'b0001;
    step();
    stuck_clr_i = 4'b0000;
    repeat (15) step();
    stuck_clr_i = 4'b0001;
    step();
    stuck_clr_i = 4'b0000;
    check("clear_beats_set", hold_stuck_o, 4'b0000);
    hold_i = 4'b0000;
    repeat (4) step();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      div_i      = DW'($urandom_range(0, 5));
      div_load_i = ($urandom_range(0, 19) == 0);
      sync_i     = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0) lab_en_i = NL'($urandom);
      if ($urandom_range(0, 24) == 0) hold_i = NL'($urandom);
      stuck_clr_i = ($urandom_range(0, 39) == 0) ? NL'($urandom) : '0;
      step();
    end

    // Asynchronous reset mid-period at DIV=5.
    div_i = 8'd5; div_load_i = 1'b1; sync_i = 1'b1; lab_en_i = 4'b1111;
    hold_i = 4'b1111; stuck_clr_i = '0;
    step();
    div_load_i = 1'b0; sync_i = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_tref", tref_o, 4'b0000);
    check("arst_hold", hold_o, 4'b0000);
    check("arst_rise", hold_rise_o, 4'b0000);
    check("arst_stuck", hold_stuck_o, 4'b0000);
    lab_en_i = 4'b0000; hold_i = 4'b0000;
    step();
    rst = 1'b0;
    repeat (6) step();
    check("post_rst_tref_off", tref_o, 4'b0000);
    lab_en_i = 4'b0101;
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
